// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional alignment checking is enabled by defining MEM_RESP_ALIGN_CHECK_EN.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    localparam int MEM_RESP_BE_W  = 4;
    localparam int MEM_RESP_CNT_W = 4;

endpackage

// File: rtl/mem_resp_array.sv
// Word array with byte-enabled synchronous write and registered read.
// Storage has no reset, so its contents survive the responder reset.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 32,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [AW-1:0]            addr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic [MEM_RESP_BE_W-1:0] be_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-lane writes and read capture; only the enabled operation fires.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < MEM_RESP_BE_W; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Handshaked load/store responder with configurable wait states.
// Define MEM_RESP_ALIGN_CHECK_EN to reject requests with addr[1:0] != 0.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [MEM_RESP_BE_W-1:0] req_be,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic                     idle
);

    localparam int AW = $clog2(DEPTH);

    mem_resp_state_t           state_q, state_d;
    logic [MEM_RESP_CNT_W-1:0] cnt_q, cnt_d;

    logic                     we_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [MEM_RESP_BE_W-1:0] be_q;

    logic rsp_valid_q;
    logic rsp_err_q;
    logic rd_ok_q;

    logic                     in_idle;
    logic                     accept;
    logic                     go_resp;
    logic                     cur_we;
    logic [ADDR_WIDTH-1:0]    cur_addr;
    logic [DATA_WIDTH-1:0]    cur_wdata;
    logic [MEM_RESP_BE_W-1:0] cur_be;
    logic                     cur_err;
    logic                     arr_we;
    logic                     arr_re;
    logic [DATA_WIDTH-1:0]    arr_rdata;

    assign in_idle = (state_q == IDLE);
    assign accept  = in_idle && req_valid;
    assign go_resp = (accept && (WAIT_CYCLES == 0)) ||
                     ((state_q == WAIT) && (cnt_q == '0));

    // With zero wait states the access happens on the accept edge itself,
    // so the live request is used before it lands in the registers.
    assign cur_we    = in_idle ? req_we    : we_q;
    assign cur_addr  = in_idle ? req_addr  : addr_q;
    assign cur_wdata = in_idle ? req_wdata : wdata_q;
    assign cur_be    = in_idle ? req_be    : be_q;

`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign cur_err = (|(cur_addr >> (AW + 2))) || (cur_addr[1:0] != 2'b00);
`else
    assign cur_err = |(cur_addr >> (AW + 2));
`endif

    assign arr_we = go_resp && cur_we && !cur_err;
    assign arr_re = go_resp && !cur_we && !cur_err;

    mem_resp_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (cur_addr[AW+1:2]),
        .wdata_i (cur_wdata),
        .be_i    (cur_be),
        .rdata_o (arr_rdata)
    );

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = MEM_RESP_CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and captured request fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    // Response flags: set on RESP entry, cleared on the response handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_ok_q     <= 1'b0;
        end else if (go_resp) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= cur_err;
            rd_ok_q     <= !cur_we && !cur_err;
        end else if ((state_q == RESP) && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_ok_q     <= 1'b0;
        end
    end

    assign req_ready = in_idle;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rd_ok_q ? arr_rdata : '0;
    assign idle      = in_idle && !req_valid;

endmodule
